uart_rx_controller: RTL and testbench

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_pkg.sv | 15 +
 rtl/rx_bit_timer.sv | 35 +++
 rtl/uart_rx_controller.sv | 134 +++++++++++++
 tb/tb_uart_rx_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and controller state encoding,
// common to the receive and transmit controllers.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uartState_t;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: loads half a bit on a start edge so strobes land mid-bit,
// then emits a one-cycle strobe once per CLOCKS_PER_BIT cycles.
module rx_bit_timer #(
    parameter int CLOCKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic strobe
);

    localparam int W = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLOCKS_PER_BIT - 1);
    localparam logic [W-1:0] HALF = W'(CLOCKS_PER_BIT >> 1);

    logic [W-1:0] r_count;
    logic         r_strobe;

    // A load suppresses the strobe so a wrap coinciding with a start edge cannot fire early.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_strobe <= 1'b0;
        end else if (load) begin
            r_count  <= HALF;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= (r_count == LAST);
            r_count  <= (r_count == LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign strobe = r_strobe;

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: synchronizes the line, frames start/data/stop bits and hands
// each byte to a valid/ready consumer, flagging framing and overrun errors.
module uart_rx_controller
    import uart_pkg::*;
#(
`ifdef FORMAL
    parameter int CLOCKS_PER_BIT = 8
`else
    parameter int CLOCKS_PER_BIT = 5000
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 busy
);

    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rxPrev;
    logic [2:0]           r_settle;
    uartState_t           r_state;
    logic [2:0]           r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;

    logic w_rxS;
    logic w_startDetected;
    logic w_strobe;

    assign w_rxS = r_sync2;

    // r_settle keeps edge detection off until the synchronizer holds real line samples,
    // so a line already low at reset release is not mistaken for a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxPrev <= 1'b1;
            r_settle <= '0;
        end else begin
            r_sync1  <= serial_in;
            r_sync2  <= r_sync1;
            r_rxPrev <= w_rxS;
            r_settle <= {r_settle[1:0], 1'b1};
        end
    end

    assign w_startDetected = (r_state == IDLE) && r_settle[2] && r_rxPrev && !w_rxS;

    rx_bit_timer #(
        .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
    ) u_bitTimer (
        .clk   (clk),
        .reset (reset),
        .load  (w_startDetected),
        .strobe(w_strobe)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_bitIdx      <= '0;
            r_shift       <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_startDetected) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_strobe) begin
                        if (!w_rxS) begin
                            r_state  <= DATA;
                            r_bitIdx <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_strobe) begin
                        r_shift[r_bitIdx] <= w_rxS;
                        if (r_bitIdx == 3'(DATA_BITS - 1)) begin
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                        end
                    end
                end
                // An accept in this same cycle frees the holding register for the new byte.
                STOP: begin
                    if (w_strobe) begin
                        if (w_rxS) begin
                            if (!rx_valid || rx_ready) begin
                                rx_data  <= r_shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun_error <= 1'b1;
                            end
                            r_state <= IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            r_state       <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    if (w_rxS) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// Self-checking bench for uart_rx_controller: frames are driven bit by bit,
// delivered bytes are checked against a scoreboard of expected bytes.
`timescale 1ns/1ps
module tb_uart_rx_controller;

    localparam int CPB = 8;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       serial_in = 1'b1;
    logic       rx_ready  = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       overrun_error;
    logic       busy;

    int nCompared    = 0;
    int nMismatched  = 0;
    int nValidCycles = 0;
    int nFraming     = 0;
    int nOverrun     = 0;
    int nViolations  = 0;
    int vc0, fr0, ov0;
    logic prevErr  = 1'b0;
    logic busySeen = 1'b0;
    logic [7:0] sbQ[$];

    uart_rx_controller #(
        .CLOCKS_PER_BIT(CPB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .framing_error(framing_error),
        .overrun_error(overrun_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at a falling clock edge; optionally pulses rx_ready
    // on the cycle the receiver strobes the stop bit.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input bit pulseReady);
        serial_in = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_in = data[i];
            waitCycles(CPB);
        end
        serial_in = stopBit;
        if (pulseReady) begin
            waitCycles(CPB - 1);
            rx_ready = 1'b1;
            waitCycles(1);
            rx_ready = 1'b0;
        end else begin
            waitCycles(CPB);
        end
    endtask

    task automatic snapCounters();
        vc0 = nValidCycles;
        fr0 = nFraming;
        ov0 = nOverrun;
    endtask

    // Monitor: samples just after the falling edge, counts pulses and scores handshakes.
    always begin
        @(negedge clk);
        #1;
        if (rx_valid)      nValidCycles++;
        if (framing_error) nFraming++;
        if (overrun_error) nOverrun++;
        if (framing_error && overrun_error) nViolations++;
        if (prevErr && (framing_error || overrun_error)) nViolations++;
        prevErr = framing_error || overrun_error;
        if (rx_valid && rx_ready) begin
            if (sbQ.size() == 0) checkOutput("sbUnderflow", 32'(sbQ.size()), 32'd1);
            else checkOutput("sbByte", {24'h0, rx_data}, {24'h0, sbQ.pop_front()});
        end
    end

    initial begin
        // Reset with the line held low; release must not look like a start bit.
        reset     = 1'b1;
        serial_in = 1'b0;
        waitCycles(4);
        checkOutput("rstData",    {24'h0, rx_data}, 32'h0);
        checkOutput("rstValid",   {31'h0, rx_valid}, 32'h0);
        checkOutput("rstFraming", {31'h0, framing_error}, 32'h0);
        checkOutput("rstOverrun", {31'h0, overrun_error}, 32'h0);
        checkOutput("rstBusy",    {31'h0, busy}, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            waitCycles(1);
            busySeen = busySeen | busy;
        end
        checkOutput("lowAtReleaseBusy", {31'h0, busySeen}, 32'h0);
        serial_in = 1'b1;
        waitCycles(5);

        // Clean 0xA5 with consumer always ready.
        snapCounters();
        rx_ready = 1'b1;
        sbQ.push_back(8'hA5);
        applyStimulus(8'hA5, 1'b1, 1'b0);
        waitCycles(4);
        checkOutput("a5ValidCycles", nValidCycles - vc0, 32'd1);
        checkOutput("a5Framing",     nFraming - fr0, 32'd0);
        checkOutput("a5Overrun",     nOverrun - ov0, 32'd0);
        checkOutput("a5Delivered",   32'(sbQ.size()), 32'd0);
        checkOutput("a5BusyAfter",   {31'h0, busy}, 32'h0);
        rx_ready = 1'b0;

        // Three-cycle glitch aborts in START.
        snapCounters();
        serial_in = 1'b0;
        waitCycles(3);
        serial_in = 1'b1;
        waitCycles(2);
        checkOutput("glitchBusyDuring", {31'h0, busy}, 32'h1);
        waitCycles(15);
        checkOutput("glitchBusyAfter", {31'h0, busy}, 32'h0);
        checkOutput("glitchValid",     nValidCycles - vc0, 32'd0);
        checkOutput("glitchErrors",    (nFraming - fr0) + (nOverrun - ov0), 32'd0);

        // 0x3C with a low stop bit, line held low afterwards.
        snapCounters();
        applyStimulus(8'h3C, 1'b0, 1'b0);
        waitCycles(10);
        checkOutput("frameErrPulses", nFraming - fr0, 32'd1);
        checkOutput("frameErrBusy",   {31'h0, busy}, 32'h1);
        checkOutput("frameErrValid",  nValidCycles - vc0, 32'd0);
        serial_in = 1'b1;
        waitCycles(5);
        checkOutput("frameErrIdle",   {31'h0, busy}, 32'h0);

        // Back-to-back 0x11, 0x22 while not ready: second byte overruns.
        snapCounters();
        sbQ.push_back(8'h11);
        applyStimulus(8'h11, 1'b1, 1'b0);
        applyStimulus(8'h22, 1'b1, 1'b0);
        waitCycles(3);
        checkOutput("ovrPulses",  nOverrun - ov0, 32'd1);
        checkOutput("ovrFraming", nFraming - fr0, 32'd0);
        checkOutput("ovrValid",   {31'h0, rx_valid}, 32'h1);
        checkOutput("ovrData",    {24'h0, rx_data}, 32'h11);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
        waitCycles(2);
        checkOutput("ovrCleared", {31'h0, rx_valid}, 32'h0);
        checkOutput("ovrDrained", 32'(sbQ.size()), 32'd0);

        // 0x55 then 0x66 with ready pulsed exactly at the second stop strobe.
        snapCounters();
        sbQ.push_back(8'h55);
        sbQ.push_back(8'h66);
        applyStimulus(8'h55, 1'b1, 1'b0);
        applyStimulus(8'h66, 1'b1, 1'b1);
        checkOutput("reloadValid", {31'h0, rx_valid}, 32'h1);
        checkOutput("reloadData",  {24'h0, rx_data}, 32'h66);
        waitCycles(3);
        checkOutput("reloadOverrun", nOverrun - ov0, 32'd0);
        rx_ready = 1'b1;
        waitCycles(1);
        rx_ready = 1'b0;
        waitCycles(2);
        checkOutput("reloadCleared", {31'h0, rx_valid}, 32'h0);

        // Reset lands on the DATA bit-4 strobe of a partial frame.
        serial_in = 1'b0;
        waitCycles(CPB);
        for (int i = 0; i < 4; i++) begin
            serial_in = (i % 2 == 0) ? 1'b1 : 1'b0;
            waitCycles(CPB);
        end
        serial_in = 1'b1;
        waitCycles(CPB - 1);
        checkOutput("midFrameBusy", {31'h0, busy}, 32'h1);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("midRstValid",   {31'h0, rx_valid}, 32'h0);
        checkOutput("midRstData",    {24'h0, rx_data}, 32'h0);
        checkOutput("midRstBusy",    {31'h0, busy}, 32'h0);
        checkOutput("midRstFraming", {31'h0, framing_error}, 32'h0);
        checkOutput("midRstOverrun", {31'h0, overrun_error}, 32'h0);
        reset = 1'b0;
        waitCycles(6);
        snapCounters();
        rx_ready = 1'b1;
        sbQ.push_back(8'h81);
        applyStimulus(8'h81, 1'b1, 1'b0);
        waitCycles(4);
        rx_ready = 1'b0;
        checkOutput("postRstDelivered", 32'(sbQ.size()), 32'd0);
        checkOutput("postRstData",      {24'h0, rx_data}, 32'h81);
        checkOutput("postRstErrors",    (nFraming - fr0) + (nOverrun - ov0), 32'd0);

        checkOutput("errPulseRules", nViolations, 32'd0);
        checkOutput("sbEmpty",       32'(sbQ.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
